// File: rtl/hsv_cls_pkg.sv
// Shared types and reset-default window set for the HSV colour classifier.
package hsv_cls_pkg;

    localparam int CLS_H_W  = 9;
    localparam int CLS_SV_W = 8;

    typedef enum logic {
        MODE_HUE  = 1'b0,
        MODE_DARK = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        FLD_H_LO  = 3'd0,
        FLD_H_HI  = 3'd1,
        FLD_S_THR = 3'd2,
        FLD_V_THR = 3'd3,
        FLD_MODE  = 3'd4,
        FLD_EN    = 3'd5
    } cfg_field_e;

    typedef struct packed {
        logic [CLS_H_W-1:0]  h_lo;
        logic [CLS_H_W-1:0]  h_hi;
        logic [CLS_SV_W-1:0] s_thr;
        logic [CLS_SV_W-1:0] v_thr;
        mode_e               mode;
        logic                en;
    } cls_cfg_t;

    localparam cls_cfg_t CFG_RED = '{
        h_lo: 9'd350, h_hi: 9'd10, s_thr: 8'd50, v_thr: 8'd40,
        mode: MODE_HUE, en: 1'b1
    };
    localparam cls_cfg_t CFG_GREEN = '{
        h_lo: 9'd80, h_hi: 9'd140, s_thr: 8'd50, v_thr: 8'd40,
        mode: MODE_HUE, en: 1'b1
    };
    localparam cls_cfg_t CFG_DARK = '{
        h_lo: 9'd0, h_hi: 9'd0, s_thr: 8'd60, v_thr: 8'd50,
        mode: MODE_DARK, en: 1'b1
    };
    localparam cls_cfg_t CFG_OFF = '{
        h_lo: 9'd0, h_hi: 9'd0, s_thr: 8'd0, v_thr: 8'd0,
        mode: MODE_HUE, en: 1'b0
    };

    function automatic cls_cfg_t default_cfg(input int k);
        case (k)
            0:       return CFG_RED;
            1:       return CFG_GREEN;
            2:       return CFG_DARK;
            default: return CFG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/hsv_colour_classifier_match.sv
// Single-class window test; a hue band with h_lo > h_hi wraps through 0.
module hsv_class_match
    import hsv_cls_pkg::*;
#(
    parameter int H_MAX = 359
) (
    input  cls_cfg_t            cfg,
    input  logic [CLS_H_W-1:0]  h,
    input  logic [CLS_SV_W-1:0] s,
    input  logic [CLS_SV_W-1:0] v,
    output logic                match
);

    logic in_band;
    logic h_legal;

    always_comb begin
        h_legal = (h <= CLS_H_W'(H_MAX));
        if (cfg.h_lo <= cfg.h_hi) begin
            in_band = (h >= cfg.h_lo) && (h <= cfg.h_hi);
        end else begin
            in_band = (h >= cfg.h_lo) || (h <= cfg.h_hi);
        end
        match = 1'b0;
        case (cfg.mode)
            MODE_HUE: match = cfg.en && (s > cfg.s_thr) && (v > cfg.v_thr)
                              && h_legal && in_band;
            MODE_DARK: match = cfg.en && (s <= cfg.s_thr) && (v <= cfg.v_thr);
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/hsv_colour_classifier.sv
// Two-stage HSV pixel classifier with programmable windows and per-frame
// saturating class histogram plus dominant-class summary.
module hsv_colour_classifier
    import hsv_cls_pkg::*;
#(
    parameter int NUM_CLASSES = 4,
    parameter int H_W         = CLS_H_W,
    parameter int H_MAX       = 359,
    parameter int SV_W        = CLS_SV_W,
    parameter int CNT_W       = 20,
    localparam int CLS_W      = $clog2(NUM_CLASSES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         in_sop,
    input  logic                         in_eop,
    input  logic [H_W-1:0]               in_h,
    input  logic [SV_W-1:0]              in_s,
    input  logic [SV_W-1:0]              in_v,
    input  logic                         cfg_we,
    input  logic [CLS_W-1:0]             cfg_class,
    input  logic [2:0]                   cfg_field,
    input  logic [H_W-1:0]               cfg_data,
    output logic                         out_valid,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic                         out_hit,
    output logic [CLS_W-1:0]             out_class,
    output logic [NUM_CLASSES-1:0]       out_onehot,
    output logic                         frame_done,
    output logic [NUM_CLASSES*CNT_W-1:0] frame_counts,
    output logic [CLS_W-1:0]             frame_dominant
);

    cls_cfg_t cfg_q [NUM_CLASSES];
    cls_cfg_t cfg_d [NUM_CLASSES];

    logic [NUM_CLASSES-1:0] match_c;
    logic [NUM_CLASSES-1:0] match_q, match_d;
    logic s1_valid_q, s1_valid_d;
    logic s1_sop_q, s1_sop_d;
    logic s1_eop_q, s1_eop_d;

    logic                   valid_q, valid_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic                   hit_q, hit_d;
    logic [CLS_W-1:0]       cls_q, cls_d;
    logic [NUM_CLASSES-1:0] onehot_q, onehot_d;

    logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
    logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
    logic [CNT_W-1:0] best_cnt;

    logic [NUM_CLASSES*CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CLS_W-1:0]             dom_q, dom_d;
    logic                         done_q, done_d;

    always_comb begin
        cfg_d = cfg_q;
        if (cfg_we && int'(cfg_class) < NUM_CLASSES) begin
            case (cfg_field_e'(cfg_field))
                FLD_H_LO:  cfg_d[cfg_class].h_lo  = cfg_data;
                FLD_H_HI:  cfg_d[cfg_class].h_hi  = cfg_data;
                FLD_S_THR: cfg_d[cfg_class].s_thr = cfg_data[SV_W-1:0];
                FLD_V_THR: cfg_d[cfg_class].v_thr = cfg_data[SV_W-1:0];
                FLD_MODE:  cfg_d[cfg_class].mode  = mode_e'(cfg_data[0]);
                FLD_EN:    cfg_d[cfg_class].en    = cfg_data[0];
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_match
        hsv_class_match #(.H_MAX(H_MAX)) u_match (
            .cfg   (cfg_q[k]),
            .h     (in_h),
            .s     (in_s),
            .v     (in_v),
            .match (match_c[k])
        );
    end

    always_comb begin
        s1_valid_d = in_valid;
        s1_sop_d   = in_valid && in_sop;
        s1_eop_d   = in_valid && in_eop;
        match_d    = in_valid ? match_c : '0;
    end

    // Scan high to low so the lowest matching index is the last to land.
    always_comb begin
        valid_d  = s1_valid_q;
        sop_d    = s1_sop_q;
        eop_d    = s1_eop_q;
        hit_d    = s1_valid_q && (|match_q);
        cls_d    = '0;
        onehot_d = '0;
        for (int k = NUM_CLASSES - 1; k >= 0; k--) begin
            if (match_q[k]) cls_d = CLS_W'(k);
        end
        if (hit_d) onehot_d[cls_d] = 1'b1;
    end

    always_comb begin
        cnt_d    = cnt_q;
        fcnt_d   = fcnt_q;
        dom_d    = dom_q;
        done_d   = 1'b0;
        best_cnt = '0;
        if (valid_q) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                if (sop_q) begin
                    cnt_d[k] = CNT_W'(onehot_q[k]);
                end else begin
                    cnt_d[k] = cnt_q[k]
                             + CNT_W'(onehot_q[k] && (cnt_q[k] != '1));
                end
            end
            if (eop_q) begin
                done_d   = 1'b1;
                dom_d    = '0;
                best_cnt = cnt_d[0];
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    fcnt_d[k*CNT_W +: CNT_W] = cnt_d[k];
                    if (cnt_d[k] > best_cnt) begin
                        best_cnt = cnt_d[k];
                        dom_d    = CLS_W'(k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                cfg_q[k] <= default_cfg(k);
                cnt_q[k] <= '0;
            end
            match_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            hit_q      <= 1'b0;
            cls_q      <= '0;
            onehot_q   <= '0;
            fcnt_q     <= '0;
            dom_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            match_q    <= match_d;
            s1_valid_q <= s1_valid_d;
            s1_sop_q   <= s1_sop_d;
            s1_eop_q   <= s1_eop_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            hit_q      <= hit_d;
            cls_q      <= cls_d;
            onehot_q   <= onehot_d;
            fcnt_q     <= fcnt_d;
            dom_q      <= dom_d;
            done_q     <= done_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_sop        = sop_q;
    assign out_eop        = eop_q;
    assign out_hit        = hit_q;
    assign out_class      = cls_q;
    assign out_onehot     = onehot_q;
    assign frame_done     = done_q;
    assign frame_counts   = fcnt_q;
    assign frame_dominant = dom_q;

endmodule

// File: tb/tb_hsv_colour_classifier.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor
// pops and compares whenever the classifier presents a pixel or frame result.
module tb_hsv_colour_classifier;

    localparam int NC   = 4;
    localparam int CW   = 4;
    localparam int MAXC = 15;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [8:0]     in_h = '0;
    logic [7:0]     in_s = '0, in_v = '0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_class = '0;
    logic [2:0]     cfg_field = '0;
    logic [8:0]     cfg_data = '0;
    logic           out_valid, out_sop, out_eop, out_hit;
    logic [1:0]     out_class;
    logic [NC-1:0]  out_onehot;
    logic           frame_done;
    logic [NC*CW-1:0] frame_counts;
    logic [1:0]     frame_dominant;

    hsv_colour_classifier #(
        .NUM_CLASSES(NC), .H_W(9), .H_MAX(359), .SV_W(8), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_h(in_h), .in_s(in_s), .in_v(in_v),
        .cfg_we(cfg_we), .cfg_class(cfg_class),
        .cfg_field(cfg_field), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_hit(out_hit), .out_class(out_class), .out_onehot(out_onehot),
        .frame_done(frame_done), .frame_counts(frame_counts),
        .frame_dominant(frame_dominant)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     cls;
        bit     hit;
        bit     sop;
        bit     eop;
        longint at;
    } px_t;

    typedef struct {
        logic [NC*CW-1:0] counts;
        int               dom;
        longint           at;
    } fr_t;

    px_t pq[$];
    fr_t fq[$];
    px_t e_px;
    fr_t e_fr;

    int m_lo[NC], m_hi[NC], m_s[NC], m_v[NC], m_dark[NC], m_en[NC];
    int m_cnt[NC];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NC; k++) begin
            m_lo[k] = 0; m_hi[k] = 0; m_s[k] = 0; m_v[k] = 0;
            m_dark[k] = 0; m_en[k] = 0; m_cnt[k] = 0;
        end
        m_lo[0] = 350; m_hi[0] = 10;  m_s[0] = 50; m_v[0] = 40; m_en[0] = 1;
        m_lo[1] = 80;  m_hi[1] = 140; m_s[1] = 50; m_v[1] = 40; m_en[1] = 1;
        m_s[2] = 60; m_v[2] = 50; m_dark[2] = 1; m_en[2] = 1;
    endfunction

    function automatic void model_cfg(input int c, input int f, input int d);
        case (f)
            0: m_lo[c] = d % 512;
            1: m_hi[c] = d % 512;
            2: m_s[c] = d % 256;
            3: m_v[c] = d % 256;
            4: m_dark[c] = d % 2;
            5: m_en[c] = d % 2;
            default: ;
        endcase
    endfunction

    function automatic int classify(input int h, input int s, input int v);
        bit ok;
        for (int k = 0; k < NC; k++) begin
            if (m_en[k] == 0) continue;
            if (m_dark[k] != 0) begin
                ok = (s <= m_s[k]) && (v <= m_v[k]);
            end else begin
                ok = (s > m_s[k]) && (v > m_v[k]) && (h <= 359);
                if (m_lo[k] <= m_hi[k]) ok = ok && h >= m_lo[k] && h <= m_hi[k];
                else ok = ok && (h >= m_lo[k] || h <= m_hi[k]);
            end
            if (ok) return k;
        end
        return -1;
    endfunction

    task automatic step(input bit vld, input int h, input int s, input int v,
                        input bit sop, input bit eop, input bit we,
                        input int wc, input int wf, input int wd);
        int  c, best;
        fr_t fr;
        px_t p;
        @(posedge clk);
        #1;
        in_valid = vld; in_sop = sop; in_eop = eop;
        in_h = 9'(h); in_s = 8'(s); in_v = 8'(v);
        cfg_we = we; cfg_class = 2'(wc); cfg_field = 3'(wf); cfg_data = 9'(wd);
        if (vld) begin
            c = classify(h, s, v);
            if (sop) for (int k = 0; k < NC; k++) m_cnt[k] = 0;
            if (c >= 0 && m_cnt[c] < MAXC) m_cnt[c]++;
            p.cls = (c < 0) ? 0 : c;
            p.hit = (c >= 0);
            p.sop = sop;
            p.eop = eop;
            p.at = cyc + 2;
            pq.push_back(p);
            if (eop) begin
                best = 0;
                for (int k = 0; k < NC; k++) begin
                    fr.counts[k*CW +: CW] = CW'(m_cnt[k]);
                    if (m_cnt[k] > m_cnt[best]) best = k;
                end
                fr.dom = best;
                fr.at = cyc + 3;
                fq.push_back(fr);
            end
        end
        if (we) model_cfg(wc, wf, wd);
    endtask

    task automatic pix(input int h, input int s, input int v, input bit sop, input bit eop);
        step(1'b1, h, s, v, sop, eop, 1'b0, 0, 0, 0);
    endtask

    task automatic cfgw(input int c, input int f, input int d);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, c, f, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    endtask

    // Pixels offered while in reset must never surface.
    task automatic do_reset();
        idle(5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1;
        in_h = 9'd0; in_s = 8'd100; in_v = 8'd100; cfg_we = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_hit", out_hit, 0);
        chk("rst_out_onehot", out_onehot, 0);
        chk("rst_out_sop_eop", {out_sop, out_eop, out_class}, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_counts", frame_counts, 0);
        chk("rst_frame_dom", frame_dominant, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (pq.size() == 0) begin
                chk("px_spurious", 1, 0);
            end else begin
                e_px = pq.pop_front();
                chk("px_latency", cyc, e_px.at);
                chk("px_hit", out_hit, e_px.hit);
                chk("px_class", out_class, e_px.cls);
                chk("px_onehot", out_onehot, e_px.hit ? (1 << e_px.cls) : 0);
                chk("px_sop", out_sop, e_px.sop);
                chk("px_eop", out_eop, e_px.eop);
            end
        end else if (pq.size() != 0 && pq[0].at <= cyc) begin
            chk("px_missing", 0, 1);
            void'(pq.pop_front());
        end
        if (frame_done) begin
            if (fq.size() == 0) begin
                chk("frame_spurious", 1, 0);
            end else begin
                e_fr = fq.pop_front();
                chk("frame_latency", cyc, e_fr.at);
                chk("frame_counts", frame_counts, e_fr.counts);
                chk("frame_dominant", frame_dominant, e_fr.dom);
            end
        end else if (fq.size() != 0 && fq[0].at <= cyc) begin
            chk("frame_missing", 0, 1);
            void'(fq.pop_front());
        end
    end

    initial begin
        model_reset();
        do_reset();
        idle(2);
        // Defaults.
        pix(355, 100, 100, 0, 0);
        pix(100, 100, 100, 0, 0);
        pix(200, 20, 20, 0, 0);
        pix(200, 100, 100, 0, 0);
        // Wrap and bounds.
        pix(350, 100, 100, 0, 0);
        pix(359, 100, 100, 0, 0);
        pix(0, 100, 100, 0, 0);
        pix(10, 100, 100, 0, 0);
        pix(349, 100, 100, 0, 0);
        pix(11, 100, 100, 0, 0);
        pix(400, 100, 100, 0, 0);
        pix(50, 50, 40, 0, 0);
        cfgw(3, 0, 100);
        cfgw(3, 1, 120);
        cfgw(3, 5, 1);
        pix(110, 100, 100, 0, 0);
        pix(120, 100, 100, 0, 0);
        // Frame of 10 c0, 5 c1, 1 miss.
        for (int i = 0; i < 10; i++) pix(355, 100, 100, i == 0, 0);
        for (int i = 0; i < 5; i++) pix(100, 100, 100, 0, 0);
        pix(200, 100, 100, 0, 1);
        idle(4);
        // Tie 5/5, class 1 first.
        for (int i = 0; i < 5; i++) pix(100, 100, 100, i == 0, 0);
        for (int i = 0; i < 5; i++) pix(5, 100, 100, 0, i == 4);
        // Saturation then restart.
        for (int i = 0; i < 20; i++) pix(90, 100, 100, i == 0, i == 19);
        pix(90, 100, 100, 1, 0);
        pix(90, 100, 100, 0, 1);
        // Disable c0 alongside pixel N.
        step(1'b1, 355, 100, 100, 1'b0, 1'b0, 1'b1, 0, 5, 0);
        pix(355, 100, 100, 0, 0);
        cfgw(0, 5, 1);
        pix(355, 100, 100, 1, 1);
        pix(10, 10, 10, 1, 1);
        // Reset mid-frame discards it.
        for (int i = 0; i < 4; i++) pix(355, 100, 100, i == 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) pix(100, 100, 100, i == 0, i == 2);
        // Randomised traffic with live reconfiguration.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 8,
                 int'($urandom_range(0, 420)),
                 int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 39) == 0,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 511)));
        end
        idle(6);
        chk("px_queue_drained", pq.size(), 0);
        chk("frame_queue_drained", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
